// File: rtl/nmos_inv_pkg.sv
// -----------------------------------------------------------------------------
// nmos_inv_pkg
//   Shared constants and helpers for the nmos_inv inverter cell.
//   CNT_W / CNT_MAX size the saturating toggle counter.
//   MAX_WIDTH is the widest inverter vector the cell supports.
//   popcount() counts set bits of a change vector that has been zero-extended
//   to MAX_WIDTH bits.
// -----------------------------------------------------------------------------
package nmos_inv_pkg;

  localparam int              CNT_W     = 16;
  localparam logic [CNT_W-1:0] CNT_MAX  = 16'hFFFF;
  localparam int              MAX_WIDTH = 32;

  typedef logic [CNT_W-1:0] cnt_t;

  // 6 bits are enough for a count of up to 32 set bits.
  function automatic logic [5:0] popcount(input logic [MAX_WIDTH-1:0] v);
    logic [5:0] cnt;
    cnt = '0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      cnt = cnt + 6'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/nmos_inv_if.sv
// -----------------------------------------------------------------------------
// nmos_inv_if
//   Bundle of the inverter cell's data/control signals.
//   en_i          advance enable (0 freezes the pipeline)
//   in_i          WIDTH inverter inputs
//   out_o         WIDTH registered inverted outputs
//   chg_o         WIDTH one-cycle change flags, one per output bit
//   toggle_cnt_o  16-bit saturating count of output transitions
//                 (only active when NMOS_INV_TOGGLE_CNT_EN is defined)
//   Modports: master drives en_i/in_i, slave (the cell) drives the outputs.
// -----------------------------------------------------------------------------
interface nmos_inv_if
  import nmos_inv_pkg::*;
#(
  parameter int WIDTH = 1
) ();

  logic             en_i;
  logic [WIDTH-1:0] in_i;
  logic [WIDTH-1:0] out_o;
  logic [WIDTH-1:0] chg_o;
  cnt_t             toggle_cnt_o;

  modport master (
    output en_i,
    output in_i,
    input  out_o,
    input  chg_o,
    input  toggle_cnt_o
  );

  modport slave (
    input  en_i,
    input  in_i,
    output out_o,
    output chg_o,
    output toggle_cnt_o
  );

endinterface

// File: rtl/nmos_inv_stage.sv
// -----------------------------------------------------------------------------
// nmos_inv_stage
//   One WIDTH-bit pipeline register with enable and synchronous reset.
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset; loads {WIDTH{RST_VAL}}, wins over en
//   en     load enable; 0 holds the current value
//   d      next value
//   q      registered value
// -----------------------------------------------------------------------------
module nmos_inv_stage #(
  parameter int   WIDTH   = 1,
  parameter logic RST_VAL = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignment so every stage samples its neighbour's
    // pre-edge value; blocking here would collapse the pipeline in simulation.
    if (!rst_n) begin
      q <= {WIDTH{RST_VAL}};
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/nmos_inv.sv
// -----------------------------------------------------------------------------
// nmos_inv
//   Clocked model of an NMOS inverter stage: out_o = ~in_i after LATENCY
//   enabled clocks, with per-bit change flags and an optional saturating
//   toggle counter for activity estimation.
//
//   Parameters
//     WIDTH    independent inverter bits (1..32)
//     LATENCY  enabled clocks from in_i sample to out_o update (1..8)
//     RST_VAL  per-bit out_o value in/after reset (input-low pull-up state)
//
//   Ports
//     clk    rising-edge clock
//     rst_n  synchronous active-low reset (wins over en_i)
//     bus    nmos_inv_if.slave: en_i, in_i in; out_o, chg_o, toggle_cnt_o out
//
//   Configuration macro: NMOS_INV_TOGGLE_CNT_EN
//     defined   -> toggle_cnt_o accumulates output bit transitions, saturating
//                  at 16'hFFFF
//     undefined -> toggle_cnt_o tied to zero, no counter logic
//
//   All outputs are registered; there is no combinational path from in_i.
// -----------------------------------------------------------------------------
module nmos_inv
  import nmos_inv_pkg::*;
#(
  parameter int   WIDTH   = 1,
  parameter int   LATENCY = 1,
  parameter logic RST_VAL = 1'b1
) (
  input logic       clk,
  input logic       rst_n,
  nmos_inv_if.slave bus
);

  logic [WIDTH-1:0] in_res;
  logic [WIDTH-1:0] stage_d [LATENCY];
  logic [WIDTH-1:0] stage_q [LATENCY];
  logic [WIDTH-1:0] chg_next;
  logic [WIDTH-1:0] chg_q;

  // An unknown or floating gate is resolved as "off" (input low), so the
  // pull-up wins and the stage sees a 1. Only a definite 1 turns the
  // pull-down on. This keeps X/Z from ever entering the pipeline.
  always_comb begin
    // NOTE: default assignment first so no path through this block can
    // leave a bit unassigned and infer a latch.
    in_res = '0;
    for (int b = 0; b < WIDTH; b++) begin
      in_res[b] = (bus.in_i[b] === 1'b1);
    end
  end

  for (genvar k = 0; k < LATENCY; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign stage_d[k] = ~in_res;
    end else begin : g_next
      assign stage_d[k] = stage_q[k-1];
    end

    nmos_inv_stage #(
      .WIDTH   (WIDTH),
      .RST_VAL (RST_VAL)
    ) u_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (bus.en_i),
      .d     (stage_d[k]),
      .q     (stage_q[k])
    );
  end

  // The change flag is computed from the value the output stage is about to
  // load, so chg_o rises on the same edge as the out_o transition it reports.
  always_comb begin
    chg_next = '0;
    if (bus.en_i) begin
      chg_next = stage_d[LATENCY-1] ^ stage_q[LATENCY-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chg_q <= '0;
    end else begin
      chg_q <= chg_next;
    end
  end

  assign bus.out_o = stage_q[LATENCY-1];
  assign bus.chg_o = chg_q;

`ifdef NMOS_INV_TOGGLE_CNT_EN
  cnt_t             cnt_q;
  logic [CNT_W:0]   cnt_sum;

  // One spare bit catches the carry so saturation never wraps.
  always_comb begin
    cnt_sum = {1'b0, cnt_q} + (CNT_W+1)'(popcount(MAX_WIDTH'(chg_next)));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (bus.en_i) begin
      cnt_q <= (cnt_sum > {1'b0, CNT_MAX}) ? CNT_MAX : cnt_sum[CNT_W-1:0];
    end
  end

  assign bus.toggle_cnt_o = cnt_q;
`else
  assign bus.toggle_cnt_o = '0;
`endif

endmodule

// File: tb/tb_nmos_inv.sv
// -----------------------------------------------------------------------------
// tb_nmos_inv
//   Drives two nmos_inv instances from one stimulus stream:
//     dut1  WIDTH=1, LATENCY=1
//     dut3  WIDTH=4, LATENCY=3
//   A queue-based model of each pipeline supplies expected out/chg/count;
//   a constant vector table and a few hand-written sequences add fixed
//   expectations for reset, latency, freeze, X input and saturation.
// -----------------------------------------------------------------------------
module tb_nmos_inv;
  import nmos_inv_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  nmos_inv_if #(.WIDTH(1)) bus1 ();
  nmos_inv_if #(.WIDTH(4)) bus3 ();

  nmos_inv #(.WIDTH(1), .LATENCY(1), .RST_VAL(1'b1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  nmos_inv #(.WIDTH(4), .LATENCY(3), .RST_VAL(1'b1)) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard: each enabled step pushes the inverted input; the entry popped
  // is the value that reaches out_o on that edge.
  logic [3:0]  q_lat1 [$];
  logic [3:0]  q_lat3 [$];
  logic [3:0]  e_out1, e_chg1, e_out3, e_chg3;
  logic [15:0] e_cnt1, e_cnt3;

  typedef struct {
    logic       rst;
    logic       en;
    logic [3:0] in;
    logic       out1;
    logic       chg1;
  } vec_t;

  vec_t tbl [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] cnt_after(input logic [15:0] c, input logic [3:0] chg);
`ifdef NMOS_INV_TOGGLE_CNT_EN
    int s;
    s = int'(c) + $countones(chg);
    return (s > 65535) ? 16'hFFFF : 16'(s);
`else
    return 16'h0000 & c & {12'h000, chg};
`endif
  endfunction

  // Drive one cycle of stimulus, advance the model, clock, then compare.
  task automatic step(input logic rst, input logic en, input logic [3:0] in);
    logic [3:0] inr;
    logic [3:0] nxt;
    rst_n     = ~rst;
    bus1.en_i = en;
    bus3.en_i = en;
    bus1.in_i = in[0];
    bus3.in_i = in;
    for (int b = 0; b < 4; b++) inr[b] = (in[b] === 1'b1);
    if (rst) begin
      q_lat1.delete();
      q_lat3.delete();
      q_lat3.push_back(4'hF);
      q_lat3.push_back(4'hF);
      e_out1 = 4'h1; e_chg1 = 4'h0; e_cnt1 = 16'h0;
      e_out3 = 4'hF; e_chg3 = 4'h0; e_cnt3 = 16'h0;
    end else if (en) begin
      q_lat1.push_back(~inr & 4'h1);
      nxt    = q_lat1.pop_front();
      e_chg1 = nxt ^ e_out1;
      e_out1 = nxt;
      e_cnt1 = cnt_after(e_cnt1, e_chg1);
      q_lat3.push_back(~inr);
      nxt    = q_lat3.pop_front();
      e_chg3 = nxt ^ e_out3;
      e_out3 = nxt;
      e_cnt3 = cnt_after(e_cnt3, e_chg3);
    end else begin
      e_chg1 = 4'h0;
      e_chg3 = 4'h0;
    end
    @(posedge clk);
    #1;
    check("dut1_out", 32'(bus1.out_o),        32'(e_out1));
    check("dut1_chg", 32'(bus1.chg_o),        32'(e_chg1));
    check("dut1_cnt", 32'(bus1.toggle_cnt_o), 32'(e_cnt1));
    check("dut3_out", 32'(bus3.out_o),        32'(e_out3));
    check("dut3_chg", 32'(bus3.chg_o),        32'(e_chg3));
    check("dut3_cnt", 32'(bus3.toggle_cnt_o), 32'(e_cnt3));
  endtask

  initial begin
    // rst en  in     out1  chg1   (dut1 uses in[0])
    tbl[0]  = '{1'b1, 1'b1, 4'hF, 1'b1, 1'b0};  // reset, input high
    tbl[1]  = '{1'b1, 1'b0, 4'hF, 1'b1, 1'b0};  // reset wins over en=0
    tbl[2]  = '{1'b0, 1'b1, 4'hF, 1'b0, 1'b1};  // release: 1 -> 0 flagged
    tbl[3]  = '{1'b0, 1'b1, 4'hF, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 4'hE, 1'b1, 1'b1};  // in 1 -> 0
    tbl[5]  = '{1'b0, 1'b1, 4'hE, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 4'hF, 1'b1, 1'b0};  // frozen
    tbl[7]  = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b0};  // frozen
    tbl[8]  = '{1'b0, 1'b1, 4'h1, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 1'b1, 4'h0, 1'b1, 1'b1};
    tbl[10] = '{1'b0, 1'b1, 4'h5, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 1'b1, 4'hA, 1'b1, 1'b1};
    tbl[12] = '{1'b1, 1'b1, 4'hF, 1'b1, 1'b0};  // mid-stream reset
    tbl[13] = '{1'b0, 1'b1, 4'h0, 1'b1, 1'b0};  // equals reset value: no flag
    tbl[14] = '{1'b0, 1'b1, 4'h3, 1'b0, 1'b1};

    for (int i = 0; i < 15; i++) begin
      step(tbl[i].rst, tbl[i].en, tbl[i].in);
      check($sformatf("tbl%0d_out1", i), 32'(bus1.out_o), 32'(tbl[i].out1));
      check($sformatf("tbl%0d_chg1", i), 32'(bus1.chg_o), 32'(tbl[i].chg1));
    end
    check("rst_cnt_after_tbl12", 32'(dut3.bus.toggle_cnt_o), 32'(e_cnt3));

    // LATENCY=3: a one-cycle low pulse on in[0] shows as a one-cycle high
    // pulse on out[0], landing on the third edge counting the sampling edge.
    step(1'b1, 1'b1, 4'hF);
    repeat (4) step(1'b0, 1'b1, 4'hF);
    check("lat3_settled", 32'(bus3.out_o), 32'h0);
    step(1'b0, 1'b1, 4'hE);
    check("lat3_edge1", 32'(bus3.out_o), 32'h0);
    step(1'b0, 1'b1, 4'hF);
    check("lat3_edge2", 32'(bus3.out_o), 32'h0);
    step(1'b0, 1'b1, 4'hF);
    check("lat3_edge3_out", 32'(bus3.out_o), 32'h1);
    check("lat3_edge3_chg", 32'(bus3.chg_o), 32'h1);
    step(1'b0, 1'b1, 4'hF);
    check("lat3_edge4_out", 32'(bus3.out_o), 32'h0);
    check("lat3_edge4_chg", 32'(bus3.chg_o), 32'h1);

    // Freeze for four cycles while the input toggles, then resume.
    repeat (3) step(1'b0, 1'b1, 4'h0);
    check("pre_freeze_out3", 32'(bus3.out_o), 32'hF);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, (i % 2 == 0) ? 4'h5 : 4'hA);
      check($sformatf("frz%0d_out3", i), 32'(bus3.out_o), 32'hF);
      check($sformatf("frz%0d_chg3", i), 32'(bus3.chg_o), 32'h0);
      check($sformatf("frz%0d_out1", i), 32'(bus1.out_o), 32'h1);
    end
    step(1'b0, 1'b1, 4'hA);
    check("resume1_out3", 32'(bus3.out_o), 32'hF);
    step(1'b0, 1'b1, 4'hA);
    check("resume2_out3", 32'(bus3.out_o), 32'hF);
    step(1'b0, 1'b1, 4'hA);
    check("resume3_out3", 32'(bus3.out_o), 32'h5);
    check("resume3_chg3", 32'(bus3.chg_o), 32'hA);

    // Unknown input resolves as input-low: outputs go high.
    repeat (3) step(1'b0, 1'b1, 4'hF);
    check("pre_x_out1", 32'(bus1.out_o), 32'h0);
    check("pre_x_out3", 32'(bus3.out_o), 32'h0);
    step(1'b0, 1'b1, 4'bxxxx);
    check("x_out1", 32'(bus1.out_o), 32'h1);
    step(1'b0, 1'b1, 4'bxxxx);
    step(1'b0, 1'b1, 4'bxxxx);
    check("x_out3", 32'(bus3.out_o), 32'hF);

    // Long alternating run drives dut3's counter through saturation.
    step(1'b1, 1'b1, 4'h0);
    for (int i = 0; i < 16400; i++) begin
      step(1'b0, 1'b1, (i % 2 == 0) ? 4'h0 : 4'hF);
    end
    step(1'b0, 1'b0, 4'h0);
`ifdef NMOS_INV_TOGGLE_CNT_EN
    check("sat_cnt3", 32'(bus3.toggle_cnt_o), 32'hFFFF);
    check("run_cnt1", 32'(bus1.toggle_cnt_o), 32'd16399);
`else
    check("off_cnt3", 32'(bus3.toggle_cnt_o), 32'h0);
    check("off_cnt1", 32'(bus1.toggle_cnt_o), 32'h0);
`endif
    step(1'b0, 1'b1, 4'h0);
    step(1'b0, 1'b1, 4'hF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
